// File: rtl/ppwm_pkg.sv
// Shared types for the PWM micro-sequencer: opcode and state encodings and
// the fixed bit positions of the instruction fields.
package ppwm_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_SET     = 4'd1,
    OP_ADD     = 4'd2,
    OP_SUB     = 4'd3,
    OP_SHL     = 4'd4,
    OP_SHR     = 4'd5,
    OP_MOV     = 4'd6,
    OP_CMPLT   = 4'd7,
    OP_CMPGE   = 4'd8,
    OP_WAIT    = 4'd9,
    OP_JUMP    = 4'd10,
    OP_BRF     = 4'd11,
    OP_LOOP    = 4'd12,
    OP_DJNZ    = 4'd13,
    OP_HALT    = 4'd14,
    OP_ILLEGAL = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWait = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam int OpcodeLsb = 0;
  localparam int RegSelLsb = 4;
  localparam int ImmLsb    = 6;

endpackage

// File: rtl/ppwm_ex_alu.sv
// Combinational data path of the executor: register arithmetic and compares.
// Control-flow opcodes are decoded by the executor, not here.
module ppwm_ex_alu
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic [3:0]               op_i,
  input  logic [COUNTER_WIDTH-1:0] operand_i,
  input  logic [COUNTER_WIDTH-1:0] mov_operand_i,
  input  logic [COUNTER_WIDTH-1:0] imm_i,
  input  logic [COUNTER_WIDTH-1:0] counter_i,
  output logic [COUNTER_WIDTH-1:0] result_o,
  output logic                     wr_en_o,
  output logic                     flag_wr_o,
  output logic                     flag_o
);

  opcode_e op;
  assign op = opcode_e'(op_i);

  always_comb begin
    result_o  = operand_i;
    wr_en_o   = 1'b0;
    flag_wr_o = 1'b0;
    flag_o    = 1'b0;
    case (op)
      OP_SET: begin result_o = imm_i;                 wr_en_o = 1'b1; end
      OP_ADD: begin result_o = operand_i + imm_i;     wr_en_o = 1'b1; end
      OP_SUB: begin result_o = operand_i - imm_i;     wr_en_o = 1'b1; end
      OP_SHL: begin result_o = operand_i << 1;        wr_en_o = 1'b1; end
      OP_SHR: begin result_o = operand_i >> 1;        wr_en_o = 1'b1; end
      OP_MOV: begin result_o = mov_operand_i;         wr_en_o = 1'b1; end
      // Compares always rewrite the flag so a stale true never leaks through.
      OP_CMPLT: begin flag_wr_o = 1'b1; flag_o = (counter_i <  operand_i); end
      OP_CMPGE: begin flag_wr_o = 1'b1; flag_o = (counter_i >= operand_i); end
      default: ;
    endcase
  end

endmodule

// File: rtl/ppwm_ex_multi.sv
// PWM micro-sequencer executor: fetches one instruction per cycle at pc_o,
// runs it under a per-period step budget and shadows R0 onto pwm_value_o.
module ppwm_ex_multi
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int PC_WIDTH      = 5,
  parameter int INSTR_WIDTH   = 12,
  parameter int NUM_REGS      = 4,
  parameter int MAX_STEPS     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic                     start_i,
  input  logic [COUNTER_WIDTH-1:0] global_counter_i,
  input  logic [INSTR_WIDTH-1:0]   instr_i,
  output logic [PC_WIDTH-1:0]      pc_o,
  output logic [COUNTER_WIDTH-1:0] pwm_value_o,
  output logic                     busy_o,
  output logic                     halted_o,
  output logic                     overrun_o,
  output logic                     illegal_o
);

  localparam int ImmWidth  = INSTR_WIDTH - ImmLsb;
  localparam int StepWidth = $clog2(MAX_STEPS + 1);
  localparam logic [1:0]           RegMask  = 2'(NUM_REGS - 1);
  localparam logic [StepWidth-1:0] MaxSteps = StepWidth'(MAX_STEPS);

  state_e                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [COUNTER_WIDTH-1:0] regs_q [NUM_REGS];
  logic [COUNTER_WIDTH-1:0] regs_d [NUM_REGS];
  logic                     flag_q, flag_d;
  logic [ImmWidth-1:0]      loop_q, loop_d;
  logic [StepWidth-1:0]     steps_q, steps_d;
  logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
  logic                     overrun_q, overrun_d;
  logic                     illegal_q, illegal_d;

  opcode_e                  op;
  logic [1:0]               rs, mov_rs;
  logic [ImmWidth-1:0]      imm;
  logic [COUNTER_WIDTH-1:0] imm_data;
  logic [PC_WIDTH-1:0]      br_off;
  logic [StepWidth-1:0]     steps_inc;
  logic                     taken, exhausted;

  logic [COUNTER_WIDTH-1:0] alu_result;
  logic                     alu_wr_en, alu_flag_wr, alu_flag;

  assign op        = opcode_e'(instr_i[OpcodeLsb +: 4]);
  assign rs        = instr_i[RegSelLsb +: 2] & RegMask;
  assign imm       = instr_i[ImmLsb +: ImmWidth];
  assign mov_rs    = imm[1:0] & RegMask;
  assign imm_data  = COUNTER_WIDTH'(imm);
  // Branch offsets are two's complement; narrower PCs simply drop the top bits.
  assign br_off    = PC_WIDTH'($signed(imm));
  assign steps_inc = steps_q + 1'b1;

  ppwm_ex_alu #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_alu (
    .op_i         (instr_i[OpcodeLsb +: 4]),
    .operand_i    (regs_q[rs]),
    .mov_operand_i(regs_q[mov_rs]),
    .imm_i        (imm_data),
    .counter_i    (global_counter_i),
    .result_o     (alu_result),
    .wr_en_o      (alu_wr_en),
    .flag_wr_o    (alu_flag_wr),
    .flag_o       (alu_flag)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    regs_d    = regs_q;
    flag_d    = flag_q;
    loop_d    = loop_q;
    steps_d   = steps_q;
    overrun_d = 1'b0;
    illegal_d = 1'b0;
    taken     = 1'b0;
    exhausted = 1'b0;
    // The shadow samples R0 as it stood before this cycle's instruction.
    shadow_d  = start_i ? regs_q[0] : shadow_q;

    if (!enable_i) begin
      state_d = StIdle;
      pc_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          pc_d = '0;
          if (start_i) begin
            state_d = StExec;
            steps_d = '0;
          end
        end
        StWait: begin
          if (start_i) begin
            state_d = StExec;
            steps_d = '0;
          end
        end
        StHalt: ;
        StExec: begin
          if (alu_wr_en)   regs_d[rs] = alu_result;
          if (alu_flag_wr) flag_d     = alu_flag;
          illegal_d = (op == OP_ILLEGAL);
          case (op)
            OP_JUMP: taken = 1'b1;
            OP_BRF:  taken = flag_q;
            OP_LOOP: loop_d = imm;
            OP_DJNZ: begin
              if (loop_q != '0) begin
                loop_d = loop_q - 1'b1;
                taken  = 1'b1;
              end
            end
            default: ;
          endcase
          pc_d = taken ? pc_q + br_off : pc_q + 1'b1;

          // A start arriving mid-period opens a fresh budget instead of expiring one.
          exhausted = (steps_inc == MaxSteps) && !start_i;
          steps_d   = start_i ? '0 : steps_inc;
          overrun_d = exhausted || start_i;

          if (op == OP_HALT) begin
            state_d = StHalt;
            pc_d    = pc_q;
          end else if (op == OP_WAIT) begin
            state_d = StWait;
            pc_d    = pc_q;
          end else if (exhausted) begin
            state_d = StWait;
          end else if ((&pc_q) && !taken) begin
            state_d = StIdle;
            pc_d    = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q[gi] <= '0;
      else        regs_q[gi] <= regs_d[gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      flag_q    <= 1'b0;
      loop_q    <= '0;
      steps_q   <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flag_q    <= flag_d;
      loop_q    <= loop_d;
      steps_q   <= steps_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
      illegal_q <= illegal_d;
    end
  end

  assign pc_o        = pc_q;
  assign pwm_value_o = shadow_q;
  assign busy_o      = (state_q == StExec);
  assign halted_o    = (state_q == StHalt);
  assign overrun_o   = overrun_q;
  assign illegal_o   = illegal_q;

endmodule
